mbist_march_ctrl: RTL and testbench

March C- sequencer that drives the BIST side of the MBIST/memory mux. It generates `bist_en`, address, write data and read/write strobes, and compares read data against the expected background. On a mismatch it reports the failing address to the address-repair logic, then restarts the march once with the repair applied. It sits between the SoC BIST control register and the mux, one instance per memory macro.

---
 rtl/mbist_march_ctrl.sv | 155 +++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer for one memory macro: drives the BIST side of the memory mux,
// checks read data against the expected background and allows a single repair-and-retry.
module mbist_march_ctrl #(
    parameter int BIST_ADDR_WD  = 9,
    parameter int BIST_DATA_WD  = 32,
    parameter int BIST_ADDR_END = (1 << BIST_ADDR_WD) - 1
) (
    input  logic                    bist_clk,
    input  logic                    bist_rst,
    input  logic                    bist_run,
    input  logic [BIST_DATA_WD-1:0] bist_rdata,
    input  logic                    bist_correct,
    output logic                    bist_en,
    output logic [BIST_ADDR_WD-1:0] bist_addr,
    output logic [BIST_DATA_WD-1:0] bist_wdata,
    output logic                    bist_wr,
    output logic                    bist_rd,
    output logic                    bist_error,
    output logic [BIST_ADDR_WD-1:0] bist_error_addr,
    output logic                    bist_done,
    output logic                    bist_fail
);

    typedef enum logic [2:0] {IDLE, RUN, ERR, REPAIR_WAIT, DONE} state_t;

    localparam logic [BIST_ADDR_WD-1:0] ADDR_LAST = BIST_ADDR_WD'(BIST_ADDR_END);
    localparam logic [BIST_ADDR_WD-1:0] ADDR_ZERO = '0;
    localparam logic [BIST_ADDR_WD-1:0] ADDR_ONE  = BIST_ADDR_WD'(1);

    state_t state, next_state;

    logic [2:0]              elem;
    logic                    phase;
    logic                    drain;
    logic [BIST_ADDR_WD-1:0] addr;
    logic                    wait_cnt;
    logic                    cmp_valid;
    logic                    exp_bit;
    logic [BIST_ADDR_WD-1:0] rd_addr_q;
    logic [BIST_ADDR_WD-1:0] err_addr_q;
    logic                    fail_q;

    logic                    two_op, down, issue, wr_op, rd_op;
    logic                    wr_bit, rd_bit, at_last, mismatch;
    logic [BIST_ADDR_WD-1:0] reload_addr;

    // Element decode: E1..E4 are read-then-write, E3/E4 walk downwards.
    always_comb begin
        two_op      = (elem >= 3'd1) && (elem <= 3'd4);
        down        = (elem == 3'd3) || (elem == 3'd4);
        issue       = (state == RUN) && !drain;
        wr_op       = issue && ((elem == 3'd0) || (two_op && phase));
        rd_op       = issue && !wr_op;
        wr_bit      = (elem == 3'd1) || (elem == 3'd3);
        rd_bit      = (elem == 3'd2) || (elem == 3'd4);
        at_last     = down ? (addr == ADDR_ZERO) : (addr == ADDR_LAST);
        reload_addr = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_LAST : ADDR_ZERO;
        mismatch    = (state == RUN) && cmp_valid &&
                      (bist_rdata != {BIST_DATA_WD{exp_bit}});
    end

    always_ff @(posedge bist_clk or posedge bist_rst) begin
        if (bist_rst) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (bist_run) next_state = RUN;
            RUN: begin
                if (!bist_run)     next_state = IDLE;
                else if (mismatch) next_state = ERR;
                else if (drain)    next_state = DONE;
            end
            ERR: begin
                if (!bist_run)         next_state = IDLE;
                else if (bist_correct) next_state = DONE;
                else                   next_state = REPAIR_WAIT;
            end
            REPAIR_WAIT: begin
                if (!bist_run)    next_state = IDLE;
                else if (wait_cnt) next_state = RUN;
            end
            DONE:        if (!bist_run) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Counters reload on every (re)entry to RUN and hold while waiting for repair,
    // so bist_addr keeps the last issued address through ERR/REPAIR_WAIT.
    always_ff @(posedge bist_clk or posedge bist_rst) begin
        if (bist_rst) begin
            elem  <= 3'd0;
            phase <= 1'b0;
            drain <= 1'b0;
            addr  <= ADDR_ZERO;
        end else if ((next_state == RUN && state != RUN) ||
                     next_state == IDLE || next_state == DONE) begin
            elem  <= 3'd0;
            phase <= 1'b0;
            drain <= 1'b0;
            addr  <= ADDR_ZERO;
        end else if (issue && next_state == RUN) begin
            if (two_op && !phase) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (at_last) begin
                    if (elem == 3'd5) begin
                        drain <= 1'b1;
                    end else begin
                        elem <= elem + 3'd1;
                        addr <= reload_addr;
                    end
                end else begin
                    addr <= down ? addr - ADDR_ONE : addr + ADDR_ONE;
                end
            end
        end
    end

    always_ff @(posedge bist_clk or posedge bist_rst) begin
        if (bist_rst) begin
            wait_cnt   <= 1'b0;
            cmp_valid  <= 1'b0;
            exp_bit    <= 1'b0;
            rd_addr_q  <= ADDR_ZERO;
            err_addr_q <= ADDR_ZERO;
            fail_q     <= 1'b0;
        end else begin
            wait_cnt  <= (state == REPAIR_WAIT);
            cmp_valid <= rd_op;
            if (rd_op) begin
                exp_bit   <= rd_bit;
                rd_addr_q <= addr;
            end
            if (mismatch) err_addr_q <= rd_addr_q;
            fail_q <= (next_state == DONE) && ((state == ERR) || fail_q);
        end
    end

    always_comb begin
        bist_en         = (state == RUN);
        bist_wr         = wr_op;
        bist_rd         = rd_op;
        bist_addr       = addr;
        bist_wdata      = wr_op ? {BIST_DATA_WD{wr_bit}} : '0;
        bist_error      = (state == ERR) && bist_run && !bist_correct;
        bist_error_addr = err_addr_q;
        bist_done       = (state == DONE);
        bist_fail       = fail_q;
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty-memory and repair models around the DUT, with a
// reference March C- op list and first-failure model driving the expected cycle trace.
module tb_mbist_march_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int N     = 4;
    localparam int TOTAL = 10 * N;

    logic          bist_clk = 1'b0;
    logic          bist_rst;
    logic          bist_run;
    logic [DW-1:0] bist_rdata;
    logic          bist_correct;
    logic          bist_en;
    logic [AW-1:0] bist_addr;
    logic [DW-1:0] bist_wdata;
    logic          bist_wr;
    logic          bist_rd;
    logic          bist_error;
    logic [AW-1:0] bist_error_addr;
    logic          bist_done;
    logic          bist_fail;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] s1[N];
    logic [DW-1:0] s0[N];
    logic [DW-1:0] mem[N];
    logic [AW-1:0] rep_addr;

    int op_addr[TOTAL];
    bit op_rd[TOTAL];
    bit op_bit[TOTAL];

    mbist_march_ctrl #(
        .BIST_ADDR_WD (AW),
        .BIST_DATA_WD (DW),
        .BIST_ADDR_END(N - 1)
    ) dut (
        .bist_clk       (bist_clk),
        .bist_rst       (bist_rst),
        .bist_run       (bist_run),
        .bist_rdata     (bist_rdata),
        .bist_correct   (bist_correct),
        .bist_en        (bist_en),
        .bist_addr      (bist_addr),
        .bist_wdata     (bist_wdata),
        .bist_wr        (bist_wr),
        .bist_rd        (bist_rd),
        .bist_error     (bist_error),
        .bist_error_addr(bist_error_addr),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail)
    );

    always #5 bist_clk = ~bist_clk;

    function automatic logic [DW-1:0] fill(bit b);
        return b ? '1 : '0;
    endfunction

    function automatic logic [DW-1:0] fault_read(logic [DW-1:0] v, int a, bit rep_ok, int rep_a);
        if (rep_ok && a == rep_a) return v;
        return (v | s1[a]) & ~s0[a];
    endfunction

    // Memory with stuck-at faults; the repaired address reads back cleanly.
    always @(posedge bist_clk) begin
        if (bist_wr) mem[bist_addr[1:0]] <= bist_wdata;
        if (bist_rd) bist_rdata <= fault_read(mem[bist_addr[1:0]], int'(bist_addr[1:0]),
                                              bist_correct, int'(rep_addr));
    end

    always @(posedge bist_clk or posedge bist_rst) begin
        if (bist_rst) begin
            bist_correct <= 1'b0;
            rep_addr     <= '0;
        end else if (bist_error) begin
            bist_correct <= 1'b1;
            rep_addr     <= bist_error_addr;
        end
    end

    // Expand the six March C- elements into a flat list of (op, address, data bit).
    function automatic void build_ops();
        int rdv[6] = '{-1, 0, 1, 0, 1, 0};
        int wrv[6] = '{0, 1, 0, 1, 0, -1};
        bit dn[6]  = '{0, 0, 0, 1, 1, 0};
        int idx = 0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                int a = dn[e] ? (N - 1 - j) : j;
                if (rdv[e] >= 0) begin
                    op_rd[idx] = 1'b1; op_bit[idx] = (rdv[e] != 0); op_addr[idx] = a; idx++;
                end
                if (wrv[e] >= 0) begin
                    op_rd[idx] = 1'b0; op_bit[idx] = (wrv[e] != 0); op_addr[idx] = a; idx++;
                end
            end
        end
    endfunction

    function automatic int model_first_fail(bit rep_ok, int rep_a);
        logic [DW-1:0] m[N];
        for (int i = 0; i < TOTAL; i++) begin
            if (!op_rd[i]) m[op_addr[i]] = fill(op_bit[i]);
            else if (fault_read(m[op_addr[i]], op_addr[i], rep_ok, rep_a) != fill(op_bit[i]))
                return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input int nfault);
        for (int a = 0; a < N; a++) begin
            s1[a] = '0;
            s0[a] = '0;
        end
        for (int i = 0; i < nfault; i++) begin
            int a = $urandom_range(0, N - 1);
            logic [DW-1:0] bitm = 32'(1) << $urandom_range(0, DW - 1);
            if ($urandom_range(0, 1) == 1) s1[a] = s1[a] | bitm;
            else                           s0[a] = s0[a] | bitm;
        end
    endtask

    task automatic do_reset();
        bist_run = 1'b0;
        bist_rst = 1'b1;
        @(negedge bist_clk);
        bist_rst = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        checkOutput({pfx, "_en"}, bist_en, 0);
        checkOutput({pfx, "_wr"}, bist_wr, 0);
        checkOutput({pfx, "_rd"}, bist_rd, 0);
        checkOutput({pfx, "_addr"}, bist_addr, 0);
        checkOutput({pfx, "_wdata"}, bist_wdata, 0);
        checkOutput({pfx, "_error"}, bist_error, 0);
        checkOutput({pfx, "_error_addr"}, bist_error_addr, 0);
        checkOutput({pfx, "_done"}, bist_done, 0);
        checkOutput({pfx, "_fail"}, bist_fail, 0);
    endtask

    task automatic check_op(input int c);
        checkOutput($sformatf("en@%0d", c), bist_en, 1);
        if (c < TOTAL) begin
            checkOutput($sformatf("wr@%0d", c), bist_wr, !op_rd[c]);
            checkOutput($sformatf("rd@%0d", c), bist_rd, op_rd[c]);
            checkOutput($sformatf("addr@%0d", c), bist_addr, op_addr[c]);
            if (!op_rd[c]) checkOutput($sformatf("wdata@%0d", c), bist_wdata, fill(op_bit[c]));
        end else begin
            checkOutput("wr_drain", bist_wr, 0);
            checkOutput("rd_drain", bist_rd, 0);
        end
    endtask

    // Starts from IDLE at a falling edge and follows the expected trace to DONE.
    task automatic run_scenario();
        int  k;
        int  c;
        int  last;
        bit  corr;
        corr = 1'b0;
        k    = model_first_fail(1'b0, 0);
        checkOutput("en_idle", bist_en, 0);
        bist_run = 1'b1;
        @(negedge bist_clk);
        c = 0;
        forever begin
            if (k < 0) begin
                if (c <= TOTAL) check_op(c);
                else begin
                    checkOutput("en_end", bist_en, 0);
                    checkOutput("done", bist_done, 1);
                    checkOutput("fail_clean", bist_fail, 0);
                    break;
                end
            end else if (c <= k + 1) begin
                check_op(c);
            end else if (c == k + 2) begin
                last = (k + 1 < TOTAL) ? k + 1 : TOTAL - 1;
                checkOutput("en_err", bist_en, 0);
                checkOutput("wr_err", bist_wr, 0);
                checkOutput("rd_err", bist_rd, 0);
                checkOutput("error_pulse", bist_error, !corr);
                checkOutput("error_addr", bist_error_addr, op_addr[k]);
                checkOutput("addr_hold", bist_addr, op_addr[last]);
            end else if (corr) begin
                checkOutput("done_fail", bist_done, 1);
                checkOutput("fail_set", bist_fail, 1);
                checkOutput("en_fail", bist_en, 0);
                checkOutput("error_quiet", bist_error, 0);
                break;
            end else if (c < k + 5) begin
                checkOutput("en_wait", bist_en, 0);
                checkOutput("error_once", bist_error, 0);
            end else begin
                corr = 1'b1;
                k    = model_first_fail(1'b1, op_addr[k]);
                c    = 0;
                check_op(0);
            end
            c++;
            @(negedge bist_clk);
        end
        bist_run = 1'b0;
        @(negedge bist_clk);
        checkOutput("done_clr", bist_done, 0);
        checkOutput("fail_clr", bist_fail, 0);
        checkOutput("en_clr", bist_en, 0);
    endtask

    task automatic abort_run(input int at);
        applyStimulus(0);
        do_reset();
        bist_run = 1'b1;
        @(negedge bist_clk);
        for (int c = 0; c < at; c++) begin
            check_op(c);
            @(negedge bist_clk);
        end
        check_op(at);
        bist_run = 1'b0;
        @(negedge bist_clk);
        checkOutput("abort_en", bist_en, 0);
        checkOutput("abort_done", bist_done, 0);
        checkOutput("abort_wr", bist_wr, 0);
        checkOutput("abort_rd", bist_rd, 0);
        checkOutput("abort_addr", bist_addr, 0);
        run_scenario();
    endtask

    task automatic reset_run(input int at);
        applyStimulus(0);
        do_reset();
        bist_run = 1'b1;
        @(negedge bist_clk);
        for (int c = 0; c < at; c++) begin
            check_op(c);
            @(negedge bist_clk);
        end
        #2 bist_rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge bist_clk);
        bist_rst = 1'b0;
        run_scenario();
    endtask

    initial begin
        build_ops();
        applyStimulus(0);
        bist_run = 1'b0;
        bist_rst = 1'b1;
        #3 check_all_zero("reset");
        @(negedge bist_clk);
        bist_rst = 1'b0;

        run_scenario();

        applyStimulus(0);
        s1[2] = 32'h0000_0020;
        do_reset();
        run_scenario();

        applyStimulus(0);
        s1[1] = 32'(1) << $urandom_range(0, DW - 1);
        s1[3] = 32'(1) << $urandom_range(0, DW - 1);
        do_reset();
        run_scenario();

        abort_run(15);
        abort_run($urandom_range(1, TOTAL - 1));
        reset_run(20);
        reset_run($urandom_range(1, TOTAL - 1));

        repeat (8) begin
            applyStimulus($urandom_range(0, 3));
            do_reset();
            run_scenario();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
